// File: rtl/clk_phase_gen.sv
// Shared-period multi-channel clock phase generator with run/halt on period boundaries.
// Outputs registered from next state (zero apparent latency); optional CLK_GATE_MASK_EN adds ch_mask.
module clk_phase_gen #(
  parameter int NUM_CH = 4,
  parameter int CNT_W  = 4,
  parameter int DIV    = 4
) (
  input  logic                    clock,
  input  logic                    reset,
  input  logic                    run_req,
  input  logic                    halt_req,
  input  logic [NUM_CH*CNT_W-1:0] phase_off,
`ifdef CLK_GATE_MASK_EN
  input  logic [NUM_CH-1:0]       ch_mask,
`endif
  output logic                    run_ack,
  output logic                    halt_ack,
  output logic                    running,
  output logic [CNT_W-1:0]        cycle_cnt,
  output logic [NUM_CH-1:0]       ch_div_clk,
  output logic [NUM_CH-1:0]       ch_en
);

  localparam logic [CNT_W:0]   DIV_V  = (CNT_W+1)'(DIV);
  localparam logic [CNT_W:0]   HALF_V = (CNT_W+1)'(DIV / 2);
  localparam logic [CNT_W-1:0] LAST   = CNT_W'(DIV - 1);

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_RUN   = 2'd1,
    S_DRAIN = 2'd2
  } state_t;

  state_t            state;
  state_t            state_nxt;
  logic [CNT_W-1:0]  cnt;
  logic [CNT_W-1:0]  cnt_nxt;
  logic              run_ack_nxt;
  logic              halt_ack_nxt;
  logic              active_nxt;
  logic              cnt_wrap;
  logic [NUM_CH-1:0] en_nxt;
  logic [NUM_CH-1:0] div_nxt;
  logic [NUM_CH-1:0] gate_nxt;

  assign cnt_wrap   = (cnt == LAST);
  assign active_nxt = (state_nxt != S_IDLE);

  always_comb begin
    state_nxt    = state;
    cnt_nxt      = cnt;
    run_ack_nxt  = 1'b0;
    halt_ack_nxt = 1'b0;
    case (state)
      S_IDLE: begin
        cnt_nxt = '0;
        if (run_req) begin
          state_nxt   = S_RUN;
          run_ack_nxt = 1'b1;
        end
      end
      S_RUN: begin
        cnt_nxt = cnt_wrap ? '0 : cnt + 1'b1;
        if (halt_req) begin
          state_nxt = S_DRAIN;
        end
      end
      S_DRAIN: begin
        // Leave only after the last phase of the period, so no channel sees a runt.
        if (cnt_wrap) begin
          state_nxt    = S_IDLE;
          cnt_nxt      = '0;
          halt_ack_nxt = 1'b1;
        end else begin
          cnt_nxt = cnt + 1'b1;
        end
      end
      default: begin
        state_nxt = S_IDLE;
        cnt_nxt   = '0;
      end
    endcase
  end

  for (genvar i = 0; i < NUM_CH; i++) begin : g_ch
    logic [CNT_W-1:0] off_raw;
    logic [CNT_W:0]   off;
    logic [CNT_W:0]   cnt_x;
    logic [CNT_W:0]   ph;

    assign off_raw = phase_off[i*CNT_W +: CNT_W];
    assign off     = ({1'b0, off_raw} >= DIV_V) ? '0 : {1'b0, off_raw};
    assign cnt_x   = {1'b0, cnt_nxt};
    assign ph      = (cnt_x >= off) ? (cnt_x - off) : (cnt_x + DIV_V - off);

`ifdef CLK_GATE_MASK_EN
    logic gated;

    // Mask only changes at this channel's period start (or while idle).
    assign gate_nxt[i] = ((state == S_IDLE) || (ph == '0)) ? ch_mask[i] : gated;

    always_ff @(posedge clock) begin
      if (reset) begin
        gated <= 1'b0;
      end else begin
        gated <= gate_nxt[i];
      end
    end
`else
    assign gate_nxt[i] = 1'b0;
`endif

    assign en_nxt[i]  = active_nxt && !gate_nxt[i] && (ph == '0);
    assign div_nxt[i] = active_nxt && !gate_nxt[i] && (ph < HALF_V);
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      state      <= S_IDLE;
      cnt        <= '0;
      run_ack    <= 1'b0;
      halt_ack   <= 1'b0;
      running    <= 1'b0;
      ch_en      <= '0;
      ch_div_clk <= '0;
    end else begin
      state      <= state_nxt;
      cnt        <= cnt_nxt;
      run_ack    <= run_ack_nxt;
      halt_ack   <= halt_ack_nxt;
      running    <= active_nxt;
      ch_en      <= en_nxt;
      ch_div_clk <= div_nxt;
    end
  end

  assign cycle_cnt = cnt;

endmodule

// File: tb/tb_clk_phase_gen.sv
// Scoreboard bench: one DIV=4 and one DIV=3 instance, directed steps push per-cycle expectations.
module tb_clk_phase_gen;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic        rst4 = 1'b1, rq4 = 1'b0, hq4 = 1'b0;
  logic [15:0] po4  = 16'h3210;
  logic [3:0]  mask4 = 4'b0000;
  logic        ra4, ha4, rn4;
  logic [3:0]  cc4, dclk4, en4;

  logic        rst3 = 1'b1, rq3 = 1'b0, hq3 = 1'b0;
  logic [15:0] po3  = 16'h3020;
  logic [3:0]  mask3 = 4'b0000;
  logic        ra3, ha3, rn3;
  logic [3:0]  cc3, dclk3, en3;

  clk_phase_gen #(.NUM_CH(4), .CNT_W(4), .DIV(4)) u4 (
    .clock(clk), .reset(rst4), .run_req(rq4), .halt_req(hq4), .phase_off(po4),
`ifdef CLK_GATE_MASK_EN
    .ch_mask(mask4),
`endif
    .run_ack(ra4), .halt_ack(ha4), .running(rn4), .cycle_cnt(cc4),
    .ch_div_clk(dclk4), .ch_en(en4)
  );

  clk_phase_gen #(.NUM_CH(4), .CNT_W(4), .DIV(3)) u3 (
    .clock(clk), .reset(rst3), .run_req(rq3), .halt_req(hq3), .phase_off(po3),
`ifdef CLK_GATE_MASK_EN
    .ch_mask(mask3),
`endif
    .run_ack(ra3), .halt_ack(ha3), .running(rn3), .cycle_cnt(cc3),
    .ch_div_clk(dclk3), .ch_en(en3)
  );

  typedef struct {
    int          cyc;
    int          sel;
    logic [63:0] tag;
    logic        ra, ha, rn;
    logic [3:0]  cc, dclk, en;
  } exp_t;

  // Hand-derived per-phase tables: [table][cnt]
  // 0: DIV4 offsets 3,2,1,0   1: DIV4 ch1 acting as offset 0
  // 2: DIV3 offsets 3,0,2,0   3: table 1 with ch1 gated
  logic [3:0] dclk_t [4][4] = '{
    '{4'b1001, 4'b0011, 4'b0110, 4'b1100},
    '{4'b1011, 4'b0011, 4'b0100, 4'b1100},
    '{4'b1101, 4'b0000, 4'b0010, 4'b0000},
    '{4'b1001, 4'b0001, 4'b0100, 4'b1100}
  };
  logic [3:0] en_t [4][4] = '{
    '{4'b0001, 4'b0010, 4'b0100, 4'b1000},
    '{4'b0011, 4'b0000, 4'b0100, 4'b1000},
    '{4'b1101, 4'b0000, 4'b0010, 4'b0000},
    '{4'b0001, 4'b0000, 4'b0100, 4'b1000}
  };

  exp_t q[$];
  int   cyc    = 0;
  int   n_chk  = 0;
  int   n_pass = 0;

  always @(posedge clk) cyc <= cyc + 1;

  always @(negedge clk) begin
    while (q.size() > 0 && q[0].cyc <= cyc) begin
      exp_t e;
      logic a_ra, a_ha, a_rn;
      logic [3:0] a_cc, a_dclk, a_en;
      e = q.pop_front();
      if (e.sel == 4) begin
        a_ra = ra4; a_ha = ha4; a_rn = rn4; a_cc = cc4; a_dclk = dclk4; a_en = en4;
      end else begin
        a_ra = ra3; a_ha = ha3; a_rn = rn3; a_cc = cc3; a_dclk = dclk3; a_en = en3;
      end
      n_chk++;
      if (e.cyc == cyc && a_ra === e.ra && a_ha === e.ha && a_rn === e.rn &&
          a_cc === e.cc && a_dclk === e.dclk && a_en === e.en) begin
        n_pass++;
      end else begin
        $display("FAIL %s dut%0d cyc=%0d: got ra=%b ha=%b rn=%b cnt=%0d dclk=%b en=%b, want ra=%b ha=%b rn=%b cnt=%0d dclk=%b en=%b (due cyc %0d)",
                 e.tag, e.sel, cyc, a_ra, a_ha, a_rn, a_cc, a_dclk, a_en,
                 e.ra, e.ha, e.rn, e.cc, e.dclk, e.en, e.cyc);
      end
    end
  end

  function automatic exp_t ex_idle(input logic [63:0] tag, input logic ha);
    exp_t e;
    e.cyc = 0; e.sel = 0; e.tag = tag;
    e.ra = 1'b0; e.ha = ha; e.rn = 1'b0; e.cc = 4'd0; e.dclk = 4'd0; e.en = 4'd0;
    return e;
  endfunction

  function automatic exp_t ex_run(input logic [63:0] tag, input int tbl, input int c, input logic ra);
    exp_t e;
    e.cyc = 0; e.sel = 0; e.tag = tag;
    e.ra = ra; e.ha = 1'b0; e.rn = 1'b1; e.cc = 4'(c);
    e.dclk = dclk_t[tbl][c]; e.en = en_t[tbl][c];
    return e;
  endfunction

  // Inputs applied now are sampled at the next edge; the expectation is for the cycle after it.
  task automatic step(input int sel, input logic rst, input logic rq, input logic hq, input exp_t e);
    if (sel == 4) begin
      rst4 = rst; rq4 = rq; hq4 = hq;
    end else begin
      rst3 = rst; rq3 = rq; hq3 = hq;
    end
    e.cyc = cyc + 1;
    e.sel = sel;
    q.push_back(e);
    @(posedge clk);
    #1;
  endtask

  initial begin
    #200000;
    $display("FAIL timeout: simulation did not complete");
    $fatal(1, "timeout");
  end

  initial begin
    // DIV=4, offsets 3,2,1,0
    for (int i = 0; i < 3; i++) step(4, 1, 0, 0, ex_idle("reset", 0));
    step(4, 0, 1, 0, ex_run("start", 0, 0, 1));
    for (int k = 1; k < 12; k++) step(4, 0, 0, 0, ex_run("run4", 0, k % 4, 0));
    step(4, 0, 0, 0, ex_run("run4", 0, 0, 0));
    step(4, 0, 0, 0, ex_run("run4", 0, 1, 0));
    step(4, 0, 0, 1, ex_run("drain", 0, 2, 0));
    step(4, 0, 0, 0, ex_run("drain", 0, 3, 0));
    step(4, 0, 0, 0, ex_idle("haltack", 1));
    step(4, 0, 0, 0, ex_idle("idle", 0));
    step(4, 0, 0, 1, ex_idle("idlehalt", 0));

    // both requests high in IDLE then in RUN; run_req ignored in DRAIN
    step(4, 0, 1, 1, ex_run("bothidle", 0, 0, 1));
    step(4, 0, 1, 1, ex_run("bothrun", 0, 1, 0));
    step(4, 0, 1, 0, ex_run("drainrq", 0, 2, 0));
    step(4, 0, 1, 0, ex_run("drainrq", 0, 3, 0));
    step(4, 0, 1, 0, ex_idle("haltack2", 1));
    step(4, 0, 1, 0, ex_run("restart", 0, 0, 1));
    step(4, 0, 0, 0, ex_run("run4", 0, 1, 0));
    step(4, 0, 0, 0, ex_run("run4", 0, 2, 0));
    step(4, 1, 0, 0, ex_idle("abort", 0));
    step(4, 0, 0, 0, ex_idle("postrst", 0));

    // out-of-range offset on ch1 behaves as offset 0; halt at cnt 0 drains the period
    po4 = 16'h3250;
    step(4, 0, 1, 0, ex_run("off5", 1, 0, 1));
    step(4, 0, 0, 1, ex_run("off5", 1, 1, 0));
    step(4, 0, 0, 0, ex_run("off5", 1, 2, 0));
    step(4, 0, 0, 0, ex_run("off5", 1, 3, 0));
    step(4, 0, 0, 0, ex_idle("off5ack", 1));
    step(4, 0, 0, 0, ex_idle("idle", 0));

`ifdef CLK_GATE_MASK_EN
    // mask raised mid-period takes effect at the channel's next phase 0
    po4 = 16'h3200;
    step(4, 0, 1, 0, ex_run("mask", 1, 0, 1));
    step(4, 0, 0, 0, ex_run("mask", 1, 1, 0));
    step(4, 0, 0, 0, ex_run("mask", 1, 2, 0));
    mask4 = 4'b0010;
    step(4, 0, 0, 0, ex_run("maskhold", 1, 3, 0));
    step(4, 0, 0, 0, ex_run("gated", 3, 0, 0));
    step(4, 0, 0, 1, ex_run("gated", 3, 1, 0));
    step(4, 0, 0, 0, ex_run("gated", 3, 2, 0));
    step(4, 0, 0, 0, ex_run("gated", 3, 3, 0));
    step(4, 0, 0, 0, ex_idle("maskack", 1));
    mask4 = 4'b0000;
`endif

    // DIV=3, offsets 3(->0),0,2,0
    step(3, 1, 0, 0, ex_idle("reset3", 0));
    step(3, 0, 1, 0, ex_run("start3", 2, 0, 1));
    for (int k = 1; k < 7; k++) step(3, 0, 0, 0, ex_run("run3", 2, k % 3, 0));
    step(3, 0, 0, 1, ex_run("drain3", 2, 1, 0));
    step(3, 0, 0, 0, ex_run("drain3", 2, 2, 0));
    step(3, 0, 0, 0, ex_idle("haltack3", 1));
    step(3, 0, 0, 0, ex_idle("idle3", 0));

    for (int i = 0; i < 8 && q.size() > 0; i++) @(posedge clk);
    if (q.size() > 0) begin
      $display("FAIL drain: %0d expectations never checked, want 0", q.size());
      n_chk += q.size();
    end
    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule

// File: doc/clk_phase_gen.md
Name: clk_phase_gen

Overview:
Parametrised clock-phase generator for the single-cycle processor top level.
- Replaces the fixed divide-by-2/divide-by-4 flops with NUM_CH channels. Each channel produces a divided clock level and a one-cycle enable pulse.
- All channels share one programmable period DIV. Each channel has its own runtime phase offset.
- A run/halt handshake starts and stops generation on period boundaries, so processor, regfile and memory domains never see a runt cycle.

Parameters:
NUM_CH, 4, number of output channels
CNT_W, 4, phase counter width
DIV, 4, period in input clocks; legal range 2..2**CNT_W

Ports:
clock  in  1  master clock; all state on rising edge
reset  in  1  synchronous, active-high reset
run_req  in  1  level; request start of generation
halt_req  in  1  level; request stop at end of current period
phase_off  in  NUM_CH*CNT_W  per-channel offset; channel i uses bits [i*CNT_W +: CNT_W]
run_ack  out  1  one-cycle pulse on entry to RUN
halt_ack  out  1  one-cycle pulse on return to IDLE from DRAIN
running  out  1  high in RUN and DRAIN
cycle_cnt  out  CNT_W  current phase counter
ch_div_clk  out  NUM_CH  divided clock level per channel
ch_en  out  NUM_CH  one-cycle enable per channel, at the channel's phase 0

Behaviour:
- Reset is synchronous and active-high. On the next edge:
  - state=IDLE, cnt=0.
  - run_ack, halt_ack, running, ch_div_clk and ch_en are all 0.
  - Reset mid-run aborts immediately: no drain, no halt_ack.
- States: IDLE, RUN, DRAIN.
  - IDLE: cnt held at 0; all channel outputs 0; halt_req ignored.
  - IDLE to RUN: when run_req=1. The first RUN cycle has cnt=0, and run_ack=1 in that cycle.
  - RUN: cnt <= (cnt==DIV-1) ? 0 : cnt+1.
  - RUN to DRAIN: when halt_req=1. halt_req wins over run_req if both are high. cnt keeps counting.
  - DRAIN: counts as RUN. After the cycle with cnt==DIV-1, go to IDLE, cnt=0, and pulse halt_ack=1 in the first IDLE cycle.
  - run_req in DRAIN is ignored. A new start requires run_req in IDLE; a held-high run_req restarts on the cycle after halt_ack.
- Channel phase, per channel i:
  - off_i = phase_off slice. If off_i >= DIV, it is treated as 0.
  - ph_i = (cnt >= off_i) ? cnt-off_i : cnt+DIV-off_i, computed at CNT_W+1 bits with no overflow.
- Channel outputs are registered from the next-state cnt, so they are cycle-aligned with cycle_cnt (zero apparent latency).
  - In RUN/DRAIN: ch_en[i] = (ph_i==0); ch_div_clk[i] = (ph_i < DIV/2), using integer divide.
  - Odd DIV gives a low-biased duty: DIV=3 is high 1, low 2.
  - In IDLE, both are 0.
- Every channel completes whole periods only. The last DRAIN cycle is cnt==DIV-1.
- phase_off is sampled every cycle. Changing it while running may shorten or lengthen one period of that channel. Software changes it only in IDLE; this is not checked in hardware.
- cycle_cnt = cnt; running is registered from state.

Optional Feature:
CLK_GATE_MASK_EN
- Defined:
  - Adds input ch_mask[NUM_CH]; 1 means the channel is gated.
  - Mask is sampled per channel only when that channel's next ph_i==0, or in IDLE.
  - While gated, ch_en[i]=0 and ch_div_clk[i]=0. Gating and ungating take effect on whole periods only, so no runt pulses.
- Undefined: no ch_mask port; all channels always active.

Test Plan:
- DIV=4, offsets {0,1,2,3}; reset 3 cycles, then run_req=1 for 1 cycle -> run_ack in RUN cycle 0; ch_en[0] at cycles 0,4,8; ch_en[3] at 3,7,11; ch_div_clk[0]=1,1,0,0 repeating; ch_div_clk[2]=0,0,1,1.
- DIV=3, offset 0 -> ch_div_clk[0]=1,0,0 repeating; ch_en[0] every 3rd cycle; cycle_cnt 0,1,2,0.
- DIV=4, halt_req=1 at cnt=1 -> running stays 1 through cnt=2,3; IDLE next cycle with halt_ack=1 for one cycle; all ch_* = 0.
- run_req and halt_req both high in RUN -> DRAIN; both high in IDLE -> RUN with run_ack.
- Reset asserted at cnt=2 in RUN -> next cycle state IDLE, cnt=0, all outputs 0, halt_ack=0.
- Offset 5 with DIV=4 -> channel behaves as offset 0. With CLK_GATE_MASK_EN: setting ch_mask[1] at cnt=2 (off 0) keeps output until end of period, then 0 from the next period's cnt=0.
